// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: owns the single UART transmitter. Command bytes from the
// command reader and ring-buffer frame dumps share it. A dump sends a header
// byte and then, for every sample slot, each channel's sample as a high byte
// followed by a low byte.
//
// Handshake semantics (all single-cycle pulses, registered):
//   cmd_req/cmd_byte : request held high by the reader until cmd_ack pulses;
//                      cmd_ack pulses in the same cycle tx_en carries cmd_byte.
//   tx_ready/tx_en   : tx_en pulses only if tx_ready was high when the decision
//                      was made and tx_en was not high in the previous cycle,
//                      so consecutive tx_en pulses are at least 2 cycles apart.
//   dump_start       : accepted only while dump_busy is low; one dump can be
//                      pending behind a command byte.
module tx_frame_scheduler #(
  parameter int          NUM_CH    = 2,
  parameter int          SAMPLE_W  = 10,
  parameter int          FRAME_LEN = 256,
  parameter int          RD_LAT    = 2,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_done,
  output logic [NUM_CH-1:0]      send_frame,
  input  logic [NUM_CH*32-1:0]   ch_data,
  input  logic                   cmd_req,
  input  logic [7:0]             cmd_byte,
  output logic                   cmd_ack,
  input  logic                   tx_ready,
  output logic                   tx_en,
  output logic [7:0]             tx_byte,
  output logic [3:0]             dbg_state
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WAIT_W = $clog2(RD_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD     = 4'd1,
    S_HDR     = 4'd2,
    S_STROBE  = 4'd3,
    S_WAIT_RD = 4'd4,
    S_SEND_HI = 4'd5,
    S_SEND_LO = 4'd6,
    S_ADV     = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pending;
  logic                r_tx_en;
  logic [7:0]          r_tx_byte;
  logic                r_cmd_ack;
  logic [CH_W-1:0]     r_ch;
  logic [IDX_W-1:0]    r_idx;
  logic [WAIT_W-1:0]   r_wait;
  logic [SAMPLE_W-1:0] r_sample;

  logic                w_can_tx;
  logic                w_tx_fire;
  logic [7:0]          w_tx_byte_nxt;
  logic                w_cmd_grant;
  logic                w_latch;
  logic                w_dump_active;
  logic                w_dump_accept;
  logic                w_last_ch;
  logic                w_last_idx;
  logic                w_rd_ready;
  logic [SAMPLE_W-1:0] w_ch_sample;
  logic [7:0]          w_hi_byte;
  logic [7:0]          w_lo_byte;
  logic                w_unused_ch;

  // The cycle after a tx_en the UART's tx_ready is not trusted.
  assign w_can_tx      = tx_ready & ~r_tx_en;
  assign w_dump_active = (r_state == S_HDR) || (r_state == S_STROBE) ||
                         (r_state == S_WAIT_RD) || (r_state == S_SEND_HI) ||
                         (r_state == S_SEND_LO) || (r_state == S_ADV);
  assign dump_busy     = r_pending | w_dump_active;
  assign w_dump_accept = dump_start & ~dump_busy;
  assign w_last_ch     = (r_ch == CH_W'(NUM_CH - 1));
  assign w_last_idx    = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign w_rd_ready    = (r_wait == WAIT_W'(RD_LAT - 1));
  assign w_hi_byte     = 8'(r_sample >> 8);
  assign w_lo_byte     = 8'(r_sample);
  assign w_unused_ch   = ^ch_data;

  assign send_frame = (r_state == S_STROBE) ? (NUM_CH'(1) << r_ch) : '0;
  assign dump_done  = (r_state == S_DONE);
  assign tx_en      = r_tx_en;
  assign tx_byte    = r_tx_byte;
  assign cmd_ack    = r_cmd_ack;
  assign dbg_state  = r_state;

  // Select the sample bits of the channel currently being read.
  always_comb begin
    w_ch_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c)) w_ch_sample = ch_data[32*c +: SAMPLE_W];
    end
  end

  // Next-state and transmit decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_fire     = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_cmd_grant   = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_req) begin
          if (w_can_tx) begin
            w_tx_fire     = 1'b1;
            w_tx_byte_nxt = cmd_byte;
            w_cmd_grant   = 1'b1;
            w_state_nxt   = S_CMD;
          end
        end else if (r_pending) begin
          w_state_nxt = S_HDR;
        end
      end
      S_CMD: w_state_nxt = S_IDLE;
      S_HDR: begin
        if (w_can_tx) begin
          w_tx_fire     = 1'b1;
          w_tx_byte_nxt = HDR_BYTE;
          w_state_nxt   = S_STROBE;
        end
      end
      S_STROBE: w_state_nxt = S_WAIT_RD;
      S_WAIT_RD: begin
        if (w_rd_ready) begin
          w_latch     = 1'b1;
          w_state_nxt = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (w_can_tx) begin
          w_tx_fire     = 1'b1;
          w_tx_byte_nxt = w_hi_byte;
          w_state_nxt   = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (w_can_tx) begin
          w_tx_fire     = 1'b1;
          w_tx_byte_nxt = w_lo_byte;
          w_state_nxt   = S_ADV;
        end
      end
      S_ADV:   w_state_nxt = (w_last_ch && w_last_idx) ? S_DONE : S_STROBE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, transmit registers and the single pending-dump flag.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_tx_en   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_cmd_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_en   <= w_tx_fire;
      r_cmd_ack <= w_cmd_grant;
      if (w_tx_fire) r_tx_byte <= w_tx_byte_nxt;
      if (w_dump_accept) begin
        r_pending <= 1'b1;
      end else if ((r_state == S_IDLE) && (w_state_nxt == S_HDR)) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Sample/channel counters, read-latency timer and sample latch.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_ch     <= '0;
      r_idx    <= '0;
      r_wait   <= '0;
      r_sample <= '0;
    end else begin
      case (r_state)
        S_HDR: begin
          r_ch  <= '0;
          r_idx <= '0;
        end
        S_STROBE: r_wait <= '0;
        S_WAIT_RD: begin
          if (w_latch) r_sample <= w_ch_sample;
          else         r_wait   <= r_wait + WAIT_W'(1);
        end
        S_ADV: begin
          if (w_last_ch) begin
            r_ch  <= '0;
            r_idx <= r_idx + IDX_W'(1);
          end else begin
            r_ch  <= r_ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a 2-channel, 2-sample frame and a
// ring-buffer model that has a 2-cycle read latency.
module tb_tx_frame_scheduler;

  localparam int NUM_CH    = 2;
  localparam int FRAME_LEN = 2;
  localparam logic [3:0] ST_SEND_LO = 4'd6;

  logic                 clk = 1'b0;
  logic                 reset_b;
  logic                 dump_start;
  logic                 dump_busy;
  logic                 dump_done;
  logic [NUM_CH-1:0]    send_frame;
  logic [NUM_CH*32-1:0] ch_data;
  logic                 cmd_req;
  logic [7:0]           cmd_byte;
  logic                 cmd_ack;
  logic                 tx_ready;
  logic                 tx_en;
  logic [7:0]           tx_byte;
  logic [3:0]           dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  tx_frame_scheduler #(
    .NUM_CH(NUM_CH), .SAMPLE_W(10), .FRAME_LEN(FRAME_LEN), .RD_LAT(2), .HDR_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset_b(reset_b), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_done(dump_done), .send_frame(send_frame), .ch_data(ch_data),
    .cmd_req(cmd_req), .cmd_byte(cmd_byte), .cmd_ack(cmd_ack), .tx_ready(tx_ready),
    .tx_en(tx_en), .tx_byte(tx_byte), .dbg_state(dbg_state)
  );

  // ring-buffer model: upper word bits set to 1 so masking is visible
  logic [31:0] mem [NUM_CH][FRAME_LEN];
  logic [31:0] st1 [NUM_CH];
  int          ptr [NUM_CH];

  initial begin
    mem[0][0] = 32'hFFFF_FFFF; // sample 3FF
    mem[0][1] = 32'hFFFF_FC01; // sample 001
    mem[1][0] = 32'hFFFF_FD55; // sample 155
    mem[1][1] = 32'hFFFF_FEAA; // sample 2AA
  end

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!reset_b) begin
        ptr[c]            <= 0;
        st1[c]            <= 32'h0;
        ch_data[32*c +: 32] <= 32'h0;
      end else begin
        if (send_frame[c]) begin
          st1[c] <= mem[c][ptr[c]];
          ptr[c] <= (ptr[c] + 1) % FRAME_LEN;
        end
        ch_data[32*c +: 32] <= st1[c];
      end
    end
  end

  // output monitor, sampled 1 time unit after the active edge
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0, last_tx = -100, gap_bad = 0, strobe_cnt = 0, done_cnt = 0;
  int done_cyc = 0, done_last_tx = 0, done_busy_bad = 0, ack_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_en) begin
      got_q.push_back(tx_byte);
      if (cyc - last_tx < 2) gap_bad++;
      last_tx = cyc;
    end
    strobe_cnt += $countones(send_frame);
    if (dump_done) begin
      done_cnt++;
      done_cyc     = cyc;
      done_last_tx = last_tx;
      if (dump_busy) done_busy_bad++;
    end
    if (cmd_ack) ack_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_dump();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic load_dump_exp();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01); exp_q.push_back(8'h55);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'hAA);
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (done_cnt != start), 1);
  endtask

  task automatic wait_bytes(input string tag, input int k, input int budget);
    int n = 0;
    while (got_q.size() < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (got_q.size() >= k), 1);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dbg_state, s);
  endtask

  initial begin
    int s0, d0, a0, sz, n;
    reset_b    = 1'b0;
    dump_start = 1'b0;
    cmd_req    = 1'b0;
    cmd_byte   = 8'h00;
    tx_ready   = 1'b1;
    tick(3);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_send_frame", send_frame, 0);
    chk("rst_state", dbg_state, 0);
    reset_b = 1'b1;
    tick(2);

    // single command byte
    cmd_byte = 8'h3C;
    cmd_req  = 1'b1;
    @(negedge clk);
    chk("cmd_tx_en", tx_en, 1);
    chk("cmd_ack", cmd_ack, 1);
    chk("cmd_byte", tx_byte, 8'h3C);
    cmd_req = 1'b0;
    tick(5);
    chk("cmd_ack_once", ack_cnt, 1);
    exp_q.push_back(8'h3C);
    cmp_seq("cmd_seq");

    // plain frame dump
    got_q.delete();
    s0 = strobe_cnt;
    pulse_dump();
    chk("dump_busy_rise", dump_busy, 1);
    wait_done("dump_timeout", 300);
    tick(3);
    load_dump_exp();
    cmp_seq("dump_seq");
    chk("dump_strobes", strobe_cnt - s0, 4);
    chk("done_after_last_tx", (done_cyc > done_last_tx), 1);
    chk("done_busy_low", done_busy_bad, 0);
    chk("busy_after_done", dump_busy, 0);

    // command and dump together, then a command raised mid-dump
    got_q.delete();
    cmd_byte   = 8'h5A;
    cmd_req    = 1'b1;
    dump_start = 1'b1;
    @(negedge clk);
    chk("both_cmd_ack", cmd_ack, 1);
    chk("both_cmd_byte", tx_byte, 8'h5A);
    chk("both_pending_busy", dump_busy, 1);
    cmd_req    = 1'b0;
    dump_start = 1'b0;
    wait_bytes("both_progress", 4, 200);
    cmd_byte = 8'h77;
    cmd_req  = 1'b1;
    a0 = ack_cnt;
    d0 = done_cnt;
    n  = 0;
    while (ack_cnt == a0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    cmd_req = 1'b0;
    chk("mid_ack_seen", (ack_cnt != a0), 1);
    chk("mid_ack_after_done", done_cnt - d0, 1);
    tick(3);
    exp_q.push_back(8'h5A);
    load_dump_exp();
    exp_q.push_back(8'h77);
    cmp_seq("both_seq");

    // tx_ready stall in SEND_LO
    got_q.delete();
    pulse_dump();
    wait_state("stall_reach", ST_SEND_LO, 200);
    tx_ready = 1'b0;
    sz = got_q.size();
    s0 = strobe_cnt;
    chk("stall_bytes_before", sz, 2);
    tick(50);
    chk("stall_no_bytes", got_q.size(), sz);
    chk("stall_no_strobes", strobe_cnt, s0);
    chk("stall_state", dbg_state, ST_SEND_LO);
    chk("stall_tx_en", tx_en, 0);
    tx_ready = 1'b1;
    wait_done("stall_timeout", 300);
    tick(3);
    load_dump_exp();
    cmp_seq("stall_seq");

    // reset mid-dump
    got_q.delete();
    d0 = done_cnt;
    pulse_dump();
    wait_bytes("rst_progress", 5, 200);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_tx_byte", tx_byte, 0);
    chk("mid_rst_cmd_ack", cmd_ack, 0);
    chk("mid_rst_busy", dump_busy, 0);
    chk("mid_rst_done", dump_done, 0);
    chk("mid_rst_send_frame", send_frame, 0);
    sz = got_q.size();
    s0 = strobe_cnt;
    tick(20);
    chk("mid_rst_no_bytes", got_q.size(), sz);
    chk("mid_rst_no_strobes", strobe_cnt, s0);
    chk("mid_rst_no_done", done_cnt, d0);
    got_q.delete();
    pulse_dump();
    wait_done("post_rst_timeout", 300);
    tick(3);
    load_dump_exp();
    cmp_seq("post_rst_seq");

    // second dump_start while busy is dropped
    got_q.delete();
    d0 = done_cnt;
    pulse_dump();
    tick(6);
    chk("busy_before_retrigger", dump_busy, 1);
    pulse_dump();
    wait_done("retrig_timeout", 300);
    tick(30);
    chk("retrig_one_done", done_cnt - d0, 1);
    chk("retrig_idle", dump_busy, 0);
    load_dump_exp();
    cmp_seq("retrig_seq");
    chk("tx_spacing", gap_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
